// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline without forwarding.
// A shift-register scoreboard of in-flight destinations drives RAW stalls, bubbles and branch squashes.
module pipe_hazard_ctrl #(
  parameter int REG_W        = 6,
  parameter int DEPTH        = 3,
  parameter int WB_BYPASS    = 1,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_rs_used,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrt,
  input  logic             redirect,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       state,
  output logic [15:0]      stall_cycles
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } hazState_e;

  // Entries the ID read can still collide with; the WB slot is excluded when the
  // register file writes before it is read.
  localparam int HZ_DEPTH = DEPTH - WB_BYPASS;
  localparam logic [2:0] FLUSH_LOAD = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;

  hazState_e        curState, nextState;
  logic [2:0]       flushCnt, nextCnt;
  logic             sbV  [DEPTH];
  logic [REG_W-1:0] sbRd [DEPTH];
  logic             rsMatch, rtMatch, hazard;
  logic [15:0]      stallCnt;

  always_comb begin
    // NOTE: every variable assigned here gets a default first so no path can infer a latch.
    rsMatch = 1'b0;
    rtMatch = 1'b0;
    for (int k = 0; k < HZ_DEPTH; k++) begin
      if (sbV[k] && id_rs_used && (id_rs == sbRd[k])) rsMatch = 1'b1;
      if (sbV[k] && id_rt_used && (id_rt == sbRd[k])) rtMatch = 1'b1;
    end
    hazard = id_valid && (curState != FLUSH) && !redirect && (rsMatch || rtMatch);
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      curState <= RUN;
      flushCnt <= 3'd0;
    end else begin
      curState <= nextState;
      flushCnt <= nextCnt;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = RUN;
    nextCnt   = flushCnt;
    if (redirect) begin
      if (FLUSH_CYCLES > 1) begin
        nextState = FLUSH;
        nextCnt   = FLUSH_LOAD;
      end else begin
        nextCnt   = 3'd0;
      end
    end else if (curState == FLUSH) begin
      if (flushCnt != 3'd0) begin
        nextState = FLUSH;
        nextCnt   = flushCnt - 3'd1;
      end
    end else if (hazard) begin
      nextState = STALL;
    end
  end

  // Output logic, highest priority first
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (redirect || (curState == FLUSH)) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (hazard) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Scoreboard valid bits; a redirect kills the wrong-path EX entry before it shifts on.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) sbV[k] <= 1'b0;
    end else begin
      sbV[0] <= id_valid && id_regwrt && !idex_bubble;
      for (int k = 1; k < DEPTH; k++) begin
        sbV[k] <= (k == 1 && redirect) ? 1'b0 : sbV[k-1];
      end
    end
  end

  // NOTE: register tags carry no reset; they are ignored until their valid bit is set.
  always_ff @(posedge clk) begin
    sbRd[0] <= id_rd;
    for (int k = 1; k < DEPTH; k++) sbRd[k] <= sbRd[k-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt <= 16'd0;
    end else if (hazard && (stallCnt != 16'hFFFF)) begin
      stallCnt <= stallCnt + 16'd1;
    end
  end

  assign state        = curState;
  assign stall_cycles = stallCnt;

endmodule
